codificacao: RTL and testbench

- Instruction encoder and program loader for the multi-cycle RISC-V datapath; the inverse of the field decoder.
- Accepts decoded fields (tipo, opcode, rd, rs1, rs2, funct3, funct7, 12-bit immediate) over a valid/ready handshake.
- Packs the fields into a 32-bit instruction word and issues one write strobe per instruction to instruction memory at a self-incrementing byte address.
- Used by the testbench/boot path to build programs that the fetch/decode stages later consume.

---
 rtl/codificacao_if.sv | 27 ++
 rtl/codificacao.sv | 162 ++++++++++++++++
 tb/tb_codificacao.sv | 202 ++++++++++++++++++++
 3 files changed

// File: rtl/codificacao_if.sv
// Handshake and field bundle between a program builder and the encoder.
// The master presents decoded instruction fields with valido.
// The slave (codificacao) answers with pronto.
// Signals: valido, pronto, tipo[2:0], opcode[6:0], rd/rs1/rs2[4:0],
//          funct3[2:0], funct7[6:0], immediate[11:0].
interface codificacao_if;
   logic        valido;
   logic        pronto;
   logic [2:0]  tipo;
   logic [6:0]  opcode;
   logic [4:0]  rd;
   logic [4:0]  rs1;
   logic [4:0]  rs2;
   logic [2:0]  funct3;
   logic [6:0]  funct7;
   logic [11:0] immediate;

   modport master (
      output valido, tipo, opcode, rd, rs1, rs2, funct3, funct7, immediate,
      input  pronto
   );

   modport slave (
      input  valido, tipo, opcode, rd, rs1, rs2, funct3, funct7, immediate,
      output pronto
   );
endinterface

// File: rtl/codificacao.sv
// codificacao: instruction encoder and program loader.
// It takes decoded fields over the bus interface, checks them and packs them
// into a 32-bit RISC-V word. It then issues one write strobe per word to
// instruction memory, using an auto-incrementing byte address.
//
// Ports:
//   clk, rst_n    clock and async active-low reset
//   bus           codificacao_if.slave (valido/pronto + decoded fields)
//   limpar        sync clear of address, counter, erro and full state
//   instrucao     encoded word (held until the next valid encode)
//   escrita       one-cycle memory write strobe
//   endereco      write byte address
//   contador      words written
//   erro          sticky flag: a field set was rejected
//   cheio         PROF words written; input is blocked until limpar/reset
//
// Optional build macro: BRANCH_IMM_RV_EN selects standard RISC-V B-format
// packing for SB (immediate input = imm[12:1]). Without it, SB reuses the
// S layout so the word matches the existing decoder.
//
// state    | meaning
// OCIOSO   | idle, pronto=1, waiting for valido
// CODIFICA | validate registered fields, load instrucao if valid
// ESCREVE  | escrita=1, address/counter advance on exit
// CHEIO    | capacity reached, only limpar or reset leave
module codificacao #(
   parameter int ADDR_W = 8,
   parameter int BASE   = 0,
   parameter int PROF   = 64
) (
   input  logic                        clk,
   input  logic                        rst_n,
   codificacao_if.slave                bus,
   input  logic                        limpar,
   output logic [31:0]                 instrucao,
   output logic                        escrita,
   output logic [ADDR_W-1:0]           endereco,
   output logic [$clog2(PROF+1)-1:0]   contador,
   output logic                        erro,
   output logic                        cheio
);

   localparam int CW = $clog2(PROF+1);

   localparam logic [1:0] OCIOSO   = 2'd0;
   localparam logic [1:0] CODIFICA = 2'd1;
   localparam logic [1:0] ESCREVE  = 2'd2;
   localparam logic [1:0] CHEIO    = 2'd3;

   localparam logic [2:0] TIPO_I  = 3'b000;
   localparam logic [2:0] TIPO_S  = 3'b010;
   localparam logic [2:0] TIPO_R  = 3'b011;
   localparam logic [2:0] TIPO_SB = 3'b110;

   logic [1:0]    estado;
   logic [2:0]    tipo_q;
   logic [6:0]    opcode_q;
   logic [4:0]    rd_q;
   logic [4:0]    rs1_q;
   logic [4:0]    rs2_q;
   logic [2:0]    funct3_q;
   logic [6:0]    funct7_q;
   logic [11:0]   imm_q;

   logic [31:0]   palavra;
   logic          tipo_ok;
   logic          campos_ok;
   logic [CW-1:0] contador_inc;

   assign bus.pronto   = (estado == OCIOSO);
   assign escrita      = (estado == ESCREVE);
   assign cheio        = (estado == CHEIO);
   assign contador_inc = contador + CW'(1);

   always_comb begin
      tipo_ok = 1'b0;
      case (tipo_q)
         TIPO_I, TIPO_S, TIPO_R, TIPO_SB: tipo_ok = 1'b1;
         default:                         tipo_ok = 1'b0;
      endcase
   end

   // The upper opcode bits double as a consistency tag for the format code.
   assign campos_ok = tipo_ok && (opcode_q[6:4] == tipo_q);

   always_comb begin
      palavra = '0;
      case (tipo_q)
         TIPO_I:  palavra = {imm_q, rs1_q, funct3_q, rd_q, opcode_q};
         TIPO_R:  palavra = {funct7_q, rs2_q, rs1_q, funct3_q, rd_q, opcode_q};
         TIPO_S:  palavra = {imm_q[11:5], rs2_q, rs1_q, funct3_q, imm_q[4:0], opcode_q};
         default: begin
`ifdef BRANCH_IMM_RV_EN
            // imm_q holds imm[12:1], so imm_q[11] is offset bit 12 and imm_q[10] is bit 11.
            palavra = {imm_q[11], imm_q[9:4], rs2_q, rs1_q, funct3_q,
                       imm_q[3:0], imm_q[10], opcode_q};
`else
            palavra = {imm_q[11:5], rs2_q, rs1_q, funct3_q, imm_q[4:0], opcode_q};
`endif
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         estado    <= OCIOSO;
         instrucao <= '0;
         endereco  <= ADDR_W'(BASE);
         contador  <= '0;
         erro      <= 1'b0;
         tipo_q    <= '0;
         opcode_q  <= '0;
         rd_q      <= '0;
         rs1_q     <= '0;
         rs2_q     <= '0;
         funct3_q  <= '0;
         funct7_q  <= '0;
         imm_q     <= '0;
      end else if (limpar) begin
         // Wins over everything; an in-flight write is dropped and not counted.
         estado   <= OCIOSO;
         endereco <= ADDR_W'(BASE);
         contador <= '0;
         erro     <= 1'b0;
      end else begin
         case (estado)
            OCIOSO: begin
               if (bus.valido) begin
                  tipo_q   <= bus.tipo;
                  opcode_q <= bus.opcode;
                  rd_q     <= bus.rd;
                  rs1_q    <= bus.rs1;
                  rs2_q    <= bus.rs2;
                  funct3_q <= bus.funct3;
                  funct7_q <= bus.funct7;
                  imm_q    <= bus.immediate;
                  estado   <= CODIFICA;
               end
            end
            CODIFICA: begin
               if (campos_ok) begin
                  instrucao <= palavra;
                  estado    <= ESCREVE;
               end else begin
                  erro   <= 1'b1;
                  estado <= OCIOSO;
               end
            end
            ESCREVE: begin
               endereco <= endereco + ADDR_W'(4);
               contador <= contador_inc;
               estado   <= (contador_inc == CW'(PROF)) ? CHEIO : OCIOSO;
            end
            CHEIO: begin
               estado <= CHEIO;
            end
            default: estado <= OCIOSO;
         endcase
      end
   end

endmodule

// File: tb/tb_codificacao.sv
module tb_codificacao;
   logic        clk;
   logic        rst_n;
   logic        limpar;
   logic [31:0] instrucao;
   logic        escrita;
   logic [7:0]  endereco;
   logic [2:0]  contador;
   logic        erro;
   logic        cheio;

   int total = 0;
   int bad   = 0;

   codificacao_if bif ();

   codificacao #(.ADDR_W(8), .BASE(0), .PROF(4)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .bus       (bif),
      .limpar    (limpar),
      .instrucao (instrucao),
      .escrita   (escrita),
      .endereco  (endereco),
      .contador  (contador),
      .erro      (erro),
      .cheio     (cheio)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

`ifdef BRANCH_IMM_RV_EN
   localparam logic [31:0] BEQ_WORD = 32'h002080E3;
`else
   localparam logic [31:0] BEQ_WORD = 32'h40208063;
`endif

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Called at a negedge; the transfer edge is the following posedge.
   task automatic send(input logic [2:0] t, input logic [6:0] op, input logic [4:0] d,
                       input logic [4:0] s1, input logic [4:0] s2, input logic [2:0] f3,
                       input logic [6:0] f7, input logic [11:0] imm);
      bif.tipo = t; bif.opcode = op; bif.rd = d; bif.rs1 = s1; bif.rs2 = s2;
      bif.funct3 = f3; bif.funct7 = f7; bif.immediate = imm;
      bif.valido = 1'b1;
      @(posedge clk);
      #1 bif.valido = 1'b0;
   endtask

   // Full valid transaction; starts and ends at a negedge.
   task automatic write_word(input string tag, input logic [2:0] t, input logic [6:0] op,
                             input logic [4:0] d, input logic [4:0] s1, input logic [4:0] s2,
                             input logic [2:0] f3, input logic [6:0] f7, input logic [11:0] imm,
                             input logic [31:0] word, input logic [7:0] addr,
                             input logic [2:0] cnt_after);
      send(t, op, d, s1, s2, f3, f7, imm);
      @(negedge clk);
      chk({tag, ".pronto_cod"}, 32'(bif.pronto), 32'd0);
      chk({tag, ".escrita_cod"}, 32'(escrita), 32'd0);
      @(negedge clk);
      chk({tag, ".escrita"}, 32'(escrita), 32'd1);
      chk({tag, ".pronto_esc"}, 32'(bif.pronto), 32'd0);
      chk({tag, ".instrucao"}, instrucao, word);
      chk({tag, ".endereco"}, 32'(endereco), 32'(addr));
      @(negedge clk);
      chk({tag, ".escrita_off"}, 32'(escrita), 32'd0);
      chk({tag, ".endereco_next"}, 32'(endereco), 32'(addr + 8'd4));
      chk({tag, ".contador"}, 32'(contador), 32'(cnt_after));
   endtask

   initial begin
      rst_n = 1'b0; limpar = 1'b0;
      bif.valido = 1'b0; bif.tipo = '0; bif.opcode = '0; bif.rd = '0; bif.rs1 = '0;
      bif.rs2 = '0; bif.funct3 = '0; bif.funct7 = '0; bif.immediate = '0;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      #1;
      chk("rst.instrucao", instrucao, 32'h0);
      chk("rst.escrita", 32'(escrita), 32'd0);
      chk("rst.endereco", 32'(endereco), 32'd0);
      chk("rst.contador", 32'(contador), 32'd0);
      chk("rst.erro", 32'(erro), 32'd0);
      chk("rst.cheio", 32'(cheio), 32'd0);
      chk("rst.pronto", 32'(bif.pronto), 32'd1);
      @(negedge clk);

      // add x3,x1,x2
      write_word("add", 3'b011, 7'b0110011, 5'd3, 5'd1, 5'd2, 3'b000, 7'd0, 12'h000,
                 32'h002081B3, 8'd0, 3'd1);
      // lb x5,-1(x0) then sw x2,8(x1) back-to-back
      write_word("lb", 3'b000, 7'b0000011, 5'd5, 5'd0, 5'd0, 3'b000, 7'd0, 12'hFFF,
                 32'hFFF00283, 8'd4, 3'd2);
      write_word("sw", 3'b010, 7'b0100011, 5'd0, 5'd1, 5'd2, 3'b010, 7'd0, 12'h008,
                 32'h0020A423, 8'd8, 3'd3);
      chk("sw.pronto_after", 32'(bif.pronto), 32'd1);

      // tipo/opcode mismatch
      send(3'b011, 7'b0010011, 5'd5, 5'd0, 5'd0, 3'b000, 7'd0, 12'hFFF);
      @(negedge clk);
      @(negedge clk);
      chk("mis.erro", 32'(erro), 32'd1);
      chk("mis.escrita", 32'(escrita), 32'd0);
      chk("mis.pronto", 32'(bif.pronto), 32'd1);
      chk("mis.endereco", 32'(endereco), 32'd12);
      chk("mis.contador", 32'(contador), 32'd3);
      chk("mis.instrucao", instrucao, 32'h0020A423);

      limpar = 1'b1;
      @(negedge clk);
      limpar = 1'b0;
      chk("clr.erro", 32'(erro), 32'd0);
      chk("clr.endereco", 32'(endereco), 32'd0);
      chk("clr.contador", 32'(contador), 32'd0);
      chk("clr.instrucao", instrucao, 32'h0020A423);
      chk("clr.pronto", 32'(bif.pronto), 32'd1);

      // unknown format code with a self-consistent opcode is still rejected
      send(3'b001, 7'b0010011, 5'd5, 5'd0, 5'd0, 3'b000, 7'd0, 12'h001);
      @(negedge clk);
      @(negedge clk);
      chk("tipo001.erro", 32'(erro), 32'd1);
      chk("tipo001.escrita", 32'(escrita), 32'd0);
      chk("tipo001.endereco", 32'(endereco), 32'd0);

      // limpar while the write strobe is up: write dropped and not counted
      send(3'b011, 7'b0110011, 5'd3, 5'd1, 5'd2, 3'b000, 7'd0, 12'h000);
      @(negedge clk);
      @(negedge clk);
      chk("clresc.escrita_on", 32'(escrita), 32'd1);
      limpar = 1'b1;
      @(negedge clk);
      limpar = 1'b0;
      chk("clresc.escrita", 32'(escrita), 32'd0);
      chk("clresc.contador", 32'(contador), 32'd0);
      chk("clresc.endereco", 32'(endereco), 32'd0);
      chk("clresc.erro", 32'(erro), 32'd0);
      chk("clresc.instrucao", instrucao, 32'h002081B3);
      chk("clresc.pronto", 32'(bif.pronto), 32'd1);

      // reset asserted during a write
      send(3'b010, 7'b0100011, 5'd0, 5'd1, 5'd2, 3'b010, 7'd0, 12'h008);
      @(negedge clk);
      @(negedge clk);
      chk("rstw.escrita_on", 32'(escrita), 32'd1);
      rst_n = 1'b0;
      #1;
      chk("rstw.escrita", 32'(escrita), 32'd0);
      chk("rstw.instrucao", instrucao, 32'h0);
      chk("rstw.endereco", 32'(endereco), 32'd0);
      chk("rstw.contador", 32'(contador), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      chk("rstw.pronto", 32'(bif.pronto), 32'd1);
      @(negedge clk);

      // fill the 4-word memory, last word is a branch
      write_word("f0", 3'b011, 7'b0110011, 5'd3, 5'd1, 5'd2, 3'b000, 7'd0, 12'h000,
                 32'h002081B3, 8'd0, 3'd1);
      write_word("f1", 3'b000, 7'b0000011, 5'd5, 5'd0, 5'd0, 3'b000, 7'd0, 12'hFFF,
                 32'hFFF00283, 8'd4, 3'd2);
      write_word("f2", 3'b010, 7'b0100011, 5'd0, 5'd1, 5'd2, 3'b010, 7'd0, 12'h008,
                 32'h0020A423, 8'd8, 3'd3);
      write_word("beq", 3'b110, 7'b1100011, 5'd0, 5'd1, 5'd2, 3'b000, 7'd0, 12'h400,
                 BEQ_WORD, 8'd12, 3'd4);
      chk("full.cheio", 32'(cheio), 32'd1);
      chk("full.pronto", 32'(bif.pronto), 32'd0);

      // fifth word offered while full must be ignored
      bif.tipo = 3'b011; bif.opcode = 7'b0110011; bif.rd = 5'd7; bif.rs1 = 5'd1;
      bif.rs2 = 5'd2; bif.funct3 = 3'b000; bif.funct7 = 7'd0; bif.immediate = 12'h0;
      bif.valido = 1'b1;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         chk("full.ignore_escrita", 32'(escrita), 32'd0);
      end
      bif.valido = 1'b0;
      chk("full.endereco", 32'(endereco), 32'd16);
      chk("full.contador", 32'(contador), 32'd4);
      chk("full.instrucao", instrucao, BEQ_WORD);
      chk("full.cheio_hold", 32'(cheio), 32'd1);

      limpar = 1'b1;
      @(negedge clk);
      limpar = 1'b0;
      chk("fullclr.endereco", 32'(endereco), 32'd0);
      chk("fullclr.contador", 32'(contador), 32'd0);
      chk("fullclr.cheio", 32'(cheio), 32'd0);
      chk("fullclr.pronto", 32'(bif.pronto), 32'd1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
